// File: rtl/alu_arb.sv
// Two-port arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE -> EXEC -> RESP.
module alu_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic [7:0]  alu_zero,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        last_grant;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  op_q;
    logic        winner;
    logic        handshake;
    logic        rsp_take;
    logic        unused_zero_bits;

    assign unused_zero_bits = ^alu_zero[7:1];

    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = RR_EN ? ~last_grant : 1'b0;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Ready is masked by rst so nothing looks accepted while in reset.
    assign req0_ready = !rst && (state == IDLE) && req0_valid && !winner;
    assign req1_ready = !rst && (state == IDLE) && req1_valid && winner;
    assign handshake  = req0_ready || req1_ready;

    assign rsp0_valid = (state == RESP) && !grant_id;
    assign rsp1_valid = (state == RESP) && grant_id;
    assign rsp_take   = grant_id ? rsp1_ready : rsp0_ready;

    assign busy   = (state != IDLE);
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            grant_id   <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_q        <= winner ? req1_a : req0_a;
                        b_q        <= winner ? req1_b : req0_b;
                        op_q       <= winner ? req1_op : req0_op;
                        grant_id   <= winner;
                        last_grant <= winner;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_c;
                    rsp_zero <= alu_zero[0];
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: round-robin DUT plus a fixed-priority twin
// sharing the same request stimulus.
module tb_alu_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [4:0]  req0_op = 0, req1_op = 0;
    logic        rsp0_ready = 0, rsp1_ready = 0;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data, alu_a, alu_b, alu_c;
    logic        rsp_zero, busy, grant_id;
    logic [4:0]  alu_op;
    logic [7:0]  alu_zero;

    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp_data, f_alu_a, f_alu_b, f_alu_c;
    logic        f_rsp_zero, f_busy, f_grant_id;
    logic [4:0]  f_alu_op;
    logic [7:0]  f_alu_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd6: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_c      = alu_model(alu_op, alu_a, alu_b);
    assign alu_zero   = {7'd0, alu_c == 32'd0};
    assign f_alu_c    = alu_model(f_alu_op, f_alu_a, f_alu_b);
    assign f_alu_zero = {7'd0, f_alu_c == 32'd0};

    alu_arb #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    alu_arb #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(f_rsp_data), .rsp_zero(f_rsp_zero),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op),
        .alu_c(f_alu_c), .alu_zero(f_alu_zero),
        .busy(f_busy), .grant_id(f_grant_id)
    );

    task automatic do_reset();
        req0_valid = 0;
        req1_valid = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1;
        req1_valid = 1;
        repeat (2) @(negedge clk);
        tests++;
        if ({req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp 00000",
                     {req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid});
        end
        tests++;
        if ({rsp_data, rsp_zero, grant_id} !== 34'd0) begin
            fails++;
            $display("FAIL reset_rsp got %h/%b/%b exp 0", rsp_data, rsp_zero, grant_id);
        end
        tests++;
        if ({alu_a, alu_b, alu_op} !== 69'd0) begin
            fails++;
            $display("FAIL reset_alu got %h %h %h exp 0", alu_a, alu_b, alu_op);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL reset_first_win got %b exp 10", {req0_ready, req1_ready});
        end
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic test_single();
        @(posedge clk);
        #1;
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 5'd1;
        rsp0_ready = 1;
        @(negedge clk);
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1 req0_valid = 0;
        @(negedge clk);
        tests++;
        if ({busy, rsp0_valid} !== 2'b10 || alu_a !== 5 || alu_b !== 3 || alu_op !== 1) begin
            fails++;
            $display("FAIL single_exec got busy=%b v=%b a=%0d b=%0d op=%0d exp 1 0 5 3 1",
                     busy, rsp0_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        tests++;
        if ({rsp0_valid, rsp1_valid, rsp_zero, grant_id} !== 4'b1000 || rsp_data !== 2) begin
            fails++;
            $display("FAIL single_rsp got v=%b%b z=%b g=%b d=%0d exp 10 0 0 2",
                     rsp0_valid, rsp1_valid, rsp_zero, grant_id, rsp_data);
        end
        @(negedge clk);
        tests++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            fails++;
            $display("FAIL single_idle got %b exp 00", {busy, rsp0_valid});
        end
    endtask

    task automatic test_zero();
        @(posedge clk);
        #1;
        req1_valid = 1; req1_a = 7; req1_b = 7; req1_op = 5'd6;
        rsp1_ready = 1;
        @(posedge clk);
        #1 req1_valid = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({rsp0_valid, rsp1_valid, rsp_zero, grant_id} !== 4'b0111 || rsp_data !== 0) begin
            fails++;
            $display("FAIL zero_rsp got v=%b%b z=%b g=%b d=%0d exp 01 1 1 0",
                     rsp0_valid, rsp1_valid, rsp_zero, grant_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit found;
        do_reset();
        req0_a = 10; req0_b = 1; req0_op = 0;
        req1_a = 20; req1_b = 2; req1_op = 0;
        rsp0_ready = 1;
        rsp1_ready = 1;
        req0_valid = 1;
        req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (rsp0_valid || rsp1_valid) begin
                    found = 1;
                    break;
                end
            end
            tests++;
            if (!found || grant_id !== i[0] || rsp_data !== (i[0] ? 32'd22 : 32'd11)) begin
                fails++;
                $display("FAIL rr_order[%0d] got found=%b g=%b d=%0d exp 1 %b %0d",
                         i, found, grant_id, rsp_data, i[0], i[0] ? 22 : 11);
            end
            tests++;
            if (f_grant_id !== 1'b0 || f_rsp0_valid !== 1'b1 || f_rsp_data !== 11) begin
                fails++;
                $display("FAIL fp_order[%0d] got g=%b v=%b d=%0d exp 0 1 11",
                         i, f_grant_id, f_rsp0_valid, f_rsp_data);
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit found;
        do_reset();
        rsp0_ready = 0;
        rsp1_ready = 1;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_a = 100; req0_b = 23; req0_op = 0;
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 0;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                found = 1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL bp_wait got no rsp0_valid exp rsp0_valid=1");
        end
        for (int j = 0; j < 5; j++) begin
            tests++;
            if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy} !== 5'b10001 ||
                rsp_data !== 123) begin
                fails++;
                $display("FAIL bp_hold[%0d] got %b d=%0d exp 10001 d=123", j,
                         {rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy}, rsp_data);
            end
            if (j < 4) @(negedge clk);
        end
        rsp0_ready = 1;
        @(negedge clk);
        tests++;
        if ({busy, rsp0_valid, req1_ready} !== 3'b001) begin
            fails++;
            $display("FAIL bp_release got %b exp 001", {busy, rsp0_valid, req1_ready});
        end
        @(posedge clk);
        #1 req1_valid = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (rsp1_valid !== 1'b1 || grant_id !== 1'b1 || rsp_data !== 2) begin
            fails++;
            $display("FAIL bp_waiter got v=%b g=%b d=%0d exp 1 1 2", rsp1_valid, grant_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        bit seen;
        do_reset();
        rsp0_ready = 0;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_a = 40; req0_b = 2; req0_op = 0;
        @(posedge clk);
        #1 req0_valid = 0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rexec_pre got busy=%b exp 1", busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, rsp0_valid, rsp1_valid, grant_id} !== 4'b0 || alu_a !== 0) begin
            fails++;
            $display("FAIL rexec_immediate got %b a=%0d exp 0000 a=0",
                     {busy, rsp0_valid, rsp1_valid, grant_id}, alu_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL rexec_no_rsp got activity=1 exp 0");
        end
        rsp0_ready = 1;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 0;
        @(posedge clk);
        #1 req0_valid = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 3) begin
            fails++;
            $display("FAIL rexec_next got v=%b d=%0d exp 1 3", rsp0_valid, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal_op();
        rsp0_ready = 1;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_a = 9; req0_b = 1; req0_op = 5'b11111;
        @(posedge clk);
        #1 req0_valid = 0;
        @(negedge clk);
        tests++;
        if (alu_op !== 5'b11111 || alu_a !== 9 || alu_b !== 1) begin
            fails++;
            $display("FAIL illegal_fwd got op=%b a=%0d b=%0d exp 11111 9 1", alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        tests++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 0 || rsp_zero !== 1'b1) begin
            fails++;
            $display("FAIL illegal_rsp got v=%b d=%0d z=%b exp 1 0 1", rsp0_valid, rsp_data, rsp_zero);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_illegal_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
